// File: rtl/bitcount_pkg.sv
// Shared definitions for the Zbb count unit: operation encoding and count widths.
package bitcount_pkg;

  typedef enum logic [1:0] {
    BC_CTZ  = 2'd0,
    BC_CLZ  = 2'd1,
    BC_CPOP = 2'd2,
    BC_RSVD = 2'd3
  } bc_op_e;

  localparam int BC_CNT_W  = 6;
  localparam int BC_DATA_W = 32;

endpackage : bitcount_pkg

// File: rtl/ctz.sv
// Single-cycle count-trailing-zeros; an all-zero operand yields the full width (32).
module ctz
  import bitcount_pkg::*;
(
  input  logic [BC_DATA_W-1:0] i_data,
  output logic [BC_CNT_W-1:0]  o_count
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    o_count = BC_CNT_W'(BC_DATA_W);
    for (int i = BC_DATA_W - 1; i >= 0; i--) begin
      if (i_data[i]) begin
        o_count = BC_CNT_W'(i);
      end
    end
  end

endmodule : ctz

// File: rtl/bitcount_unit.sv
// Two-stage CTZ/CLZ/CPOP execute unit with valid/ready flow control and flush.
// CLZ reuses the ctz counter on the bit-reversed operand captured in S1.
module bitcount_unit
  import bitcount_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [BC_DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BC_DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]     out_tag
);

  logic                 r_s1_valid;
  bc_op_e               r_s1_op;
  logic [TAG_W-1:0]     r_s1_tag;
  logic [BC_DATA_W-1:0] r_s1_data;

  logic                 r_s2_valid;
  logic [TAG_W-1:0]     r_s2_tag;
  logic [BC_CNT_W-1:0]  r_s2_result;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_accept;
  bc_op_e               w_in_op;
  logic [BC_DATA_W-1:0] w_rev;
  logic [BC_DATA_W-1:0] w_s1_data_next;
  logic [BC_CNT_W-1:0]  w_ctz;
  logic [BC_CNT_W-1:0]  w_result;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;
  assign w_accept = in_valid && w_s1_adv;
  assign w_in_op  = bc_op_e'(in_op);

  genvar gi;
  generate
    for (gi = 0; gi < BC_DATA_W; gi++) begin : g_rev
      assign w_rev[gi] = in_data[BC_DATA_W-1-gi];
    end
  endgenerate

  assign w_s1_data_next = (w_in_op == BC_CLZ) ? w_rev : in_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= BC_CTZ;
      r_s1_tag   <= '0;
      r_s1_data  <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_op   <= w_in_op;
        r_s1_tag  <= in_tag;
        r_s1_data <= w_s1_data_next;
      end
    end
  end

  ctz u_ctz (
    .i_data  (r_s1_data),
    .o_count (w_ctz)
  );

  // Popcount adder tree: 16 x 2-bit, 8 x 3-bit, 4 x 4-bit, 2 x 5-bit, 1 x 6-bit.
  logic [1:0] w_pc1 [16];
  logic [2:0] w_pc2 [8];
  logic [3:0] w_pc3 [4];
  logic [4:0] w_pc4 [2];
  logic [5:0] w_pc5;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_pc1
      assign w_pc1[gi] = {1'b0, r_s1_data[2*gi]} + {1'b0, r_s1_data[2*gi+1]};
    end
    for (gi = 0; gi < 8; gi++) begin : g_pc2
      assign w_pc2[gi] = {1'b0, w_pc1[2*gi]} + {1'b0, w_pc1[2*gi+1]};
    end
    for (gi = 0; gi < 4; gi++) begin : g_pc3
      assign w_pc3[gi] = {1'b0, w_pc2[2*gi]} + {1'b0, w_pc2[2*gi+1]};
    end
    for (gi = 0; gi < 2; gi++) begin : g_pc4
      assign w_pc4[gi] = {1'b0, w_pc3[2*gi]} + {1'b0, w_pc3[2*gi+1]};
    end
  endgenerate

  assign w_pc5 = {1'b0, w_pc4[0]} + {1'b0, w_pc4[1]};

  always_comb begin
    w_result = '0;
    case (r_s1_op)
      BC_CTZ, BC_CLZ: w_result = w_ctz;
      BC_CPOP:        w_result = w_pc5;
      default:        w_result = '0;
    endcase
  end

  // Data registers only load with a valid S1 entry, so a stalled result stays put.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_tag    <= '0;
      r_s2_result <= '0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_tag    <= r_s1_tag;
        r_s2_result <= w_result;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_tag    = r_s2_tag;
  assign out_result = BC_DATA_W'(r_s2_result);

endmodule : bitcount_unit

// File: tb/tb_bitcount_unit.sv
// Self-checking bench for bitcount_unit: directed cases plus random traffic
// compared against an in-order scoreboard fed by a behavioural count model.
module tb_bitcount_unit;
  import bitcount_pkg::*;

  localparam int TAG_W = 5;

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  bitcount_unit #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_deliv  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference semantics straight from the operation definitions.
  function automatic logic [31:0] ref_count(input logic [1:0] op, input logic [31:0] d);
    int n;
    n = 0;
    case (op)
      2'd0: while (n < 32 && d[n] == 1'b0) n++;
      2'd1: while (n < 32 && d[31-n] == 1'b0) n++;
      2'd2: for (int i = 0; i < 32; i++) n += int'(d[i]);
      default: n = 0;
    endcase
    return 32'(n);
  endfunction

  // Monitor: retire outputs against the scoreboard, then record new accepts.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_deliv++;
        if (sb.size() == 0) begin
          check_eq("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("out_tag", 32'(out_tag), 32'(e.tag));
          check_eq("out_result", out_result, e.res);
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        exp_t e;
        e.tag = in_tag;
        e.res = ref_count(in_op, in_data);
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_data();
    int unsigned sel;
    int unsigned k;
    sel = $urandom_range(0, 7);
    k   = $urandom_range(0, 31);
    case (sel)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1 << k;
      3:       return ~(32'h1 << k);
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input logic [1:0] op, input logic [31:0] d, input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_tag   = t;
  endtask

  // One request into an idle pipe with out_ready high; result due after the next edge.
  task automatic single(input string name, input logic [1:0] op, input logic [31:0] d,
                        input logic [TAG_W-1:0] t, input logic [31:0] exp);
    out_ready = 1'b1;
    set_req(op, d, t);
    tick();
    in_valid = 1'b0;
    check_eq({name, "_early_valid"}, 32'(out_valid), 32'd0);
    tick();
    check_eq({name, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({name, "_result"}, out_result, exp);
    check_eq({name, "_tag"}, 32'(out_tag), 32'(t));
    tick();
  endtask

  int          accepted;
  int          n0;
  bit          hs;
  logic [31:0] held_res;
  logic [TAG_W-1:0] held_tag;
  logic [1:0]  bp_op1;
  logic [31:0] bp_data1;

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_data   = 32'd0;
    in_tag    = '0;
    out_ready = 1'b1;
    #2;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_result", out_result, 32'd0);
    check_eq("rst_out_tag", 32'(out_tag), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);

    single("ctz8",       BC_CTZ,  32'h0000_0008, 5'd3,  32'd3);
    single("clz10000",   BC_CLZ,  32'h0001_0000, 5'd4,  32'd15);
    single("cpop",       BC_CPOP, 32'hF0F0_0001, 5'd5,  32'd9);
    single("ctz0",       BC_CTZ,  32'h0,         5'd6,  32'd32);
    single("clz0",       BC_CLZ,  32'h0,         5'd7,  32'd32);
    single("ctz_msb",    BC_CTZ,  32'h8000_0000, 5'd8,  32'd31);
    single("clz1",       BC_CLZ,  32'h1,         5'd9,  32'd31);
    single("cpop_ones",  BC_CPOP, 32'hFFFF_FFFF, 5'd10, 32'd32);
    single("cpop0",      BC_CPOP, 32'h0,         5'd11, 32'd0);
    single("rsvd",       BC_RSVD, 32'h0000_1234, 5'd31, 32'd0);

    // Backpressure: four back-to-back requests against a 5-cycle output stall.
    n0        = n_deliv;
    out_ready = 1'b0;
    accepted  = 0;
    bp_op1    = 2'($urandom_range(0, 2));
    bp_data1  = rand_data();
    set_req(bp_op1, bp_data1, 5'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      tick();
      if (hs) begin
        accepted++;
        if (accepted < 4) set_req(2'($urandom_range(0, 3)), rand_data(), 5'(accepted + 1));
        else in_valid = 1'b0;
      end
      if (c == 2) begin
        held_res = out_result;
        held_tag = out_tag;
      end
    end
    check_eq("bp_accepts", 32'(accepted), 32'd2);
    check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
    check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    check_eq("bp_head_tag", 32'(out_tag), 32'd1);
    check_eq("bp_head_result", out_result, ref_count(bp_op1, bp_data1));
    check_eq("bp_hold_tag", 32'(out_tag), 32'(held_tag));
    check_eq("bp_hold_result", out_result, held_res);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      tick();
      if (hs) begin
        accepted++;
        if (accepted < 4) set_req(2'($urandom_range(0, 3)), rand_data(), 5'(accepted + 1));
        else in_valid = 1'b0;
      end
    end
    check_eq("bp_total_accepts", 32'(accepted), 32'd4);
    check_eq("bp_delivered", 32'(n_deliv - n0), 32'd4);
    check_eq("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Flush with S1 and S2 full and a third request offered during flush.
    out_ready = 1'b0;
    set_req(BC_CPOP, 32'h0000_00FF, 5'd12);
    tick();
    set_req(BC_CTZ, 32'h0000_0100, 5'd13);
    tick();
    set_req(BC_CLZ, 32'h0000_0001, 5'd14);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush1_out_valid", 32'(out_valid), 32'd0);
    check_eq("flush1_in_ready", 32'(in_ready), 32'd1);
    n0 = n_deliv;
    out_ready = 1'b1;
    repeat (4) tick();
    check_eq("flush1_no_results", 32'(n_deliv - n0), 32'd0);

    // Flush with one op in S1 and a new request handshaken in the flush cycle.
    set_req(BC_CPOP, 32'h0000_000F, 5'd15);
    tick();
    set_req(BC_CPOP, 32'h0000_0007, 5'd16);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush2_out_valid", 32'(out_valid), 32'd0);
    repeat (3) tick();
    check_eq("flush2_no_results", 32'(n_deliv - n0), 32'd0);
    single("post_flush", BC_CLZ, 32'h0000_0100, 5'd17, 32'd23);

    // Asynchronous reset between edges with both stages holding work.
    out_ready = 1'b0;
    set_req(BC_CPOP, 32'h0000_00FF, 5'd18);
    tick();
    set_req(BC_CTZ, 32'h0000_0010, 5'd19);
    tick();
    in_valid = 1'b0;
    check_eq("prereset_out_valid", 32'(out_valid), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_out_result", out_result, 32'd0);
    check_eq("async_rst_out_tag", 32'(out_tag), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    check_eq("rst_release_in_ready", 32'(in_ready), 32'd1);
    n0 = n_deliv;
    out_ready = 1'b1;
    repeat (4) tick();
    check_eq("rst_no_stale", 32'(n_deliv - n0), 32'd0);

    // Random traffic with random backpressure and occasional flush.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_data   = rand_data();
      in_tag    = TAG_W'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check_eq("rand_drained", 32'(sb.size()), 32'd0);
    check_eq("rand_idle_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bitcount_unit
